// File: rtl/tri_dispatcher.sv
// ---------------------------------------------------------------------------
// tri_dispatcher
//
// Purpose:
//   Queues submitted triangles in a small FIFO and hands them one at a time
//   to a rasterizer. Each popped triangle first has its signed area
//   evaluated. Degenerate (zero-area) triangles are retired immediately as
//   culled. All other triangles are launched with a one-cycle start pulse.
//   The dispatcher then counts the fragments the rasterizer emits until it
//   reports idle, and retires the triangle with that fragment count.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_tri_valid / o_tri_ready  submission handshake (ready = queue not full)
//   i_v{0,1,2}_{x,y}           submitted vertices, signed CORD_WIDTH each
//   o_rast_start               one-cycle start pulse to the rasterizer
//   o_rast_v{0,1,2}_{x,y}      vertices of the triangle in flight
//   i_rast_done                rasterizer idle
//   i_rast_frag_valid          rasterizer emitted a fragment this cycle
//   o_tri_done                 one-cycle retire pulse
//   o_tri_culled               retired triangle was degenerate (with done)
//   o_frag_count               fragments of retired triangle (with done)
//   o_busy                     queue non-empty or FSM not idle
// ---------------------------------------------------------------------------
module tri_dispatcher #(
  parameter int CORD_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_tri_valid,
  output logic                         o_tri_ready,
  input  logic signed [CORD_WIDTH-1:0] i_v0_x,
  input  logic signed [CORD_WIDTH-1:0] i_v0_y,
  input  logic signed [CORD_WIDTH-1:0] i_v1_x,
  input  logic signed [CORD_WIDTH-1:0] i_v1_y,
  input  logic signed [CORD_WIDTH-1:0] i_v2_x,
  input  logic signed [CORD_WIDTH-1:0] i_v2_y,
  output logic                         o_rast_start,
  output logic signed [CORD_WIDTH-1:0] o_rast_v0_x,
  output logic signed [CORD_WIDTH-1:0] o_rast_v0_y,
  output logic signed [CORD_WIDTH-1:0] o_rast_v1_x,
  output logic signed [CORD_WIDTH-1:0] o_rast_v1_y,
  output logic signed [CORD_WIDTH-1:0] o_rast_v2_x,
  output logic signed [CORD_WIDTH-1:0] o_rast_v2_y,
  input  logic                         i_rast_done,
  input  logic                         i_rast_frag_valid,
  output logic                         o_tri_done,
  output logic                         o_tri_culled,
  output logic [2*CORD_WIDTH:0]        o_frag_count,
  output logic                         o_busy
);

  localparam int CW     = CORD_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int TW     = 6 * CW;
  localparam int PW     = 2 * CW + 2;
  localparam int AREA_W = 2 * CW + 3;
  localparam int CNT_W  = 2 * CW + 1;

  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_SCAN   = 3'd3,
    ST_RETIRE = 3'd4
  } state_e;

  // Sign-extends a coordinate to product width so the edge differences and
  // their products cannot overflow.
  function automatic logic signed [PW-1:0] sext_cord(input logic [CW-1:0] c);
    return {{(PW-CW){c[CW-1]}}, c};
  endfunction

  // ---------------------------------------------------------------------
  // Triangle FIFO
  // ---------------------------------------------------------------------
  logic [TW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] in_entry_s;
  logic [TW-1:0] head_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          fifo_nonempty_d_s;
  logic          push_s;
  logic          pop_s;

  state_e        state_q;

  assign in_entry_s   = {i_v0_x, i_v0_y, i_v1_x, i_v1_y, i_v2_x, i_v2_y};
  assign head_s       = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  // The extra MSB tells a full queue (wrapped once) from an empty one.
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready depends only on the current occupancy; a pop in the same cycle
  // does not open a slot until the following cycle.
  assign o_tri_ready  = ~fifo_full_s;
  assign push_s       = i_tri_valid & ~fifo_full_s;
  assign pop_s        = (state_q == ST_IDLE) & ~fifo_empty_s & i_rast_done;

  // Next-state pointers; push and pop advance independently.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  assign fifo_nonempty_d_s = (wr_ptr_d != rd_ptr_d);

  // FIFO pointer and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= {TW{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_s) begin
        fifo_mem_q[wr_ptr_q[AW-1:0]] <= in_entry_s;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------
  logic                  check_ph_q;
  logic signed [CW-1:0]  v0_x_q, v0_y_q, v1_x_q, v1_y_q, v2_x_q, v2_y_q;
  logic signed [PW-1:0]  prod_a_q, prod_b_q;
  logic signed [PW-1:0]  d10_x_s, d10_y_s, d20_x_s, d20_y_s;
  logic signed [AREA_W-1:0] area_s;
  logic [CNT_W-1:0]      frag_cnt_q;
  logic                  cull_pend_q;
  logic                  rast_start_q;
  logic                  tri_done_q;
  logic                  tri_culled_q;
  logic [CNT_W-1:0]      frag_count_q;
  logic                  busy_q;
  logic                  fsm_active_d_s;

  assign d10_x_s = sext_cord(v1_x_q) - sext_cord(v0_x_q);
  assign d10_y_s = sext_cord(v1_y_q) - sext_cord(v0_y_q);
  assign d20_x_s = sext_cord(v2_x_q) - sext_cord(v0_x_q);
  assign d20_y_s = sext_cord(v2_y_q) - sext_cord(v0_y_q);
  // Area is formed from the registered products one cycle later, so CHECK
  // spends one cycle multiplying and one cycle deciding.
  assign area_s  = {prod_a_q[PW-1], prod_a_q} - {prod_b_q[PW-1], prod_b_q};

  // The FSM is active next cycle if it pops now or is mid-triangle and not
  // about to leave RETIRE.
  assign fsm_active_d_s = pop_s | (state_q == ST_CHECK) |
                          (state_q == ST_LAUNCH) | (state_q == ST_SCAN);

  // FSM state, vertex registers, area pipeline, fragment counter, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      check_ph_q   <= 1'b0;
      v0_x_q       <= {CW{1'b0}};
      v0_y_q       <= {CW{1'b0}};
      v1_x_q       <= {CW{1'b0}};
      v1_y_q       <= {CW{1'b0}};
      v2_x_q       <= {CW{1'b0}};
      v2_y_q       <= {CW{1'b0}};
      prod_a_q     <= {PW{1'b0}};
      prod_b_q     <= {PW{1'b0}};
      frag_cnt_q   <= {CNT_W{1'b0}};
      cull_pend_q  <= 1'b0;
      rast_start_q <= 1'b0;
      tri_done_q   <= 1'b0;
      tri_culled_q <= 1'b0;
      frag_count_q <= {CNT_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      rast_start_q <= 1'b0;
      tri_done_q   <= 1'b0;
      busy_q       <= fifo_nonempty_d_s | fsm_active_d_s;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            v0_x_q     <= head_s[6*CW-1 -: CW];
            v0_y_q     <= head_s[5*CW-1 -: CW];
            v1_x_q     <= head_s[4*CW-1 -: CW];
            v1_y_q     <= head_s[3*CW-1 -: CW];
            v2_x_q     <= head_s[2*CW-1 -: CW];
            v2_y_q     <= head_s[CW-1 -: CW];
            check_ph_q <= 1'b0;
            state_q    <= ST_CHECK;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (!check_ph_q) begin
            prod_a_q   <= d10_x_s * d20_y_s;
            prod_b_q   <= d20_x_s * d10_y_s;
            check_ph_q <= 1'b1;
            state_q    <= ST_CHECK;
          end else begin
            check_ph_q <= 1'b0;
            if (area_s == {AREA_W{1'b0}}) begin
              cull_pend_q <= 1'b1;
              frag_cnt_q  <= {CNT_W{1'b0}};
              state_q     <= ST_RETIRE;
            end else begin
              // Start is registered here so it is high exactly during LAUNCH.
              cull_pend_q  <= 1'b0;
              rast_start_q <= 1'b1;
              state_q      <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          frag_cnt_q <= {CNT_W{1'b0}};
          state_q    <= ST_SCAN;
        end
        ST_SCAN: begin
          if (i_rast_frag_valid && (frag_cnt_q != CNT_MAX)) begin
            frag_cnt_q <= frag_cnt_q + CNT_ONE;
          end else begin
            frag_cnt_q <= frag_cnt_q;
          end
          if (i_rast_done) begin
            state_q <= ST_RETIRE;
          end else begin
            state_q <= ST_SCAN;
          end
        end
        ST_RETIRE: begin
          tri_done_q   <= 1'b1;
          tri_culled_q <= cull_pend_q;
          frag_count_q <= frag_cnt_q;
          state_q      <= ST_IDLE;
        end
        default: begin
          check_ph_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rast_start = rast_start_q;
  assign o_rast_v0_x  = v0_x_q;
  assign o_rast_v0_y  = v0_y_q;
  assign o_rast_v1_x  = v1_x_q;
  assign o_rast_v1_y  = v1_y_q;
  assign o_rast_v2_x  = v2_x_q;
  assign o_rast_v2_y  = v2_y_q;
  assign o_tri_done   = tri_done_q;
  assign o_tri_culled = tri_culled_q;
  assign o_frag_count = frag_count_q;
  assign o_busy       = busy_q;

endmodule
